// File: rtl/bus_hold_pkg.sv
// Shared types and constants for the PCjr bus-hold controller.
package bus_hold_pkg;

  localparam int unsigned MAX_NUM_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_GRANT    = 2'd2,
    ST_RELEASE  = 2'd3
  } bus_hold_state_t;

  // Index width for a requester count; a single requester still needs one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_hold_controller_rr_pick.sv
// Combinational round-robin selector.
// Ports: req_i/elig_i per-requester request and eligibility, ptr_i search start;
//        winner_oh_c one-hot winner, winner_idx_c its index, valid_c any winner.
module rr_pick
  import bus_hold_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] winner_oh_c,
  output logic [PTR_W-1:0]   winner_idx_c,
  output logic               valid_c
);

  logic [NUM_REQ-1:0] cand_c;
  int unsigned        sum_c;
  logic [PTR_W-1:0]   cand_idx_c;

  assign cand_c = req_i & elig_i;

  // First eligible request at or after ptr_i, wrapping past NUM_REQ-1.
  always_comb begin
    winner_oh_c  = '0;
    winner_idx_c = '0;
    valid_c      = 1'b0;
    sum_c        = 0;
    cand_idx_c   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum_c = 32'(ptr_i) + k;
      if (sum_c >= NUM_REQ) sum_c = sum_c - NUM_REQ;
      cand_idx_c = PTR_W'(sum_c);
      if (!valid_c && cand_c[cand_idx_c]) begin
        valid_c                  = 1'b1;
        winner_idx_c             = cand_idx_c;
        winner_oh_c[cand_idx_c]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_hold_controller.sv
// Arbitrates the PCjr system bus between the 8088 and secondary masters.
// Ports: clock/reset_n; cpu_clock_posedge/negedge CPU edge strobes; req level
//        requests; cpu_hlda from the CPU; cpu_hold to the CPU; grant one-hot;
//        HLDA qualified acknowledge; busy not idle; protocol_error sticky.
module bus_hold_controller
  import bus_hold_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned MAX_HOLD_CLKS = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cpu_clock_posedge,
  input  logic               cpu_clock_negedge,
  input  logic [NUM_REQ-1:0] req,
  input  logic               cpu_hlda,
  output logic               cpu_hold,
  output logic [NUM_REQ-1:0] grant,
  output logic               HLDA,
  output logic               busy,
  output logic               protocol_error
);

  localparam int unsigned      PTR_W   = ptr_width(NUM_REQ);
  localparam int unsigned      CNT_W   = $clog2(MAX_HOLD_CLKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD_CLKS);
  localparam logic [PTR_W-1:0] IDX_TOP = PTR_W'(NUM_REQ - 1);

  bus_hold_state_t    state_q, state_d;
  logic               hold_q, hold_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               hlda_q;
  logic               busy_q;
  logic               perr_q, perr_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] elig_q, elig_d;
  logic [PTR_W-1:0]   win_idx_q, win_idx_d;
  logic [NUM_REQ-1:0] win_oh_q, win_oh_d;
  logic               abort_q, abort_d;

  logic [NUM_REQ-1:0] pick_oh_c;
  logic [PTR_W-1:0]   pick_idx_c;
  logic               pick_valid_c;
  logic               win_req_c;
  logic [PTR_W-1:0]   next_ptr_c;
  logic               unused_negedge;

  // The falling-edge strobe carries no state here.
  assign unused_negedge = cpu_clock_negedge;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req_i        (req),
    .elig_i       (elig_q),
    .ptr_i        (rr_ptr_q),
    .winner_oh_c  (pick_oh_c),
    .winner_idx_c (pick_idx_c),
    .valid_c      (pick_valid_c)
  );

  assign win_req_c  = |(req & win_oh_q);
  assign next_ptr_c = (win_idx_q == IDX_TOP) ? '0 : win_idx_q + PTR_W'(1);

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    grant_d   = grant_q;
    perr_d    = perr_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    win_idx_d = win_idx_q;
    win_oh_d  = win_oh_q;
    abort_d   = abort_q;
    // A requester regains eligibility once its request is seen low.
    elig_d    = elig_q | ~req;

    unique case (state_q)
      ST_IDLE: begin
        // HOLD left high by a protocol error is dropped on the CPU edge first.
        if (hold_q) begin
          if (cpu_clock_posedge) hold_d = 1'b0;
        end else if (cpu_clock_posedge && pick_valid_c) begin
          win_idx_d = pick_idx_c;
          win_oh_d  = pick_oh_c;
          hold_d    = 1'b1;
          abort_d   = 1'b0;
          state_d   = ST_WAIT_ACK;
        end
      end

      ST_WAIT_ACK: begin
        // A request withdrawn before the ack still completes the handshake.
        if (!win_req_c) abort_d = 1'b1;
        if (cpu_hlda) begin
          grant_d = win_oh_q;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (!cpu_hlda) begin
          grant_d  = '0;
          perr_d   = 1'b1;
          rr_ptr_d = next_ptr_c;
          if (cpu_clock_posedge) hold_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (!win_req_c || abort_q) begin
          grant_d = '0;
          state_d = ST_RELEASE;
        end else if (cnt_q == CNT_MAX) begin
          grant_d = '0;
          elig_d  = elig_d & ~win_oh_q;
          state_d = ST_RELEASE;
        end else if (cpu_clock_posedge) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        if (cpu_clock_posedge) hold_d = 1'b0;
        if (!cpu_hlda) begin
          rr_ptr_d = next_ptr_c;
          state_d  = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      hold_q    <= 1'b0;
      grant_q   <= '0;
      hlda_q    <= 1'b0;
      busy_q    <= 1'b0;
      perr_q    <= 1'b0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      elig_q    <= '1;
      win_idx_q <= '0;
      win_oh_q  <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      hlda_q    <= |grant_d;
      busy_q    <= (state_d != ST_IDLE);
      perr_q    <= perr_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      elig_q    <= elig_d;
      win_idx_q <= win_idx_d;
      win_oh_q  <= win_oh_d;
      abort_q   <= abort_d;
    end
  end

  assign cpu_hold       = hold_q;
  assign grant          = grant_q;
  assign HLDA           = hlda_q;
  assign busy           = busy_q;
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_bus_hold_controller.sv
// Self-checking bench for bus_hold_controller (2 requesters, 4-clock tenure).
module tb_bus_hold_controller;

  localparam int unsigned ACK_DLY = 3;

  logic       clock;
  logic       reset_n;
  logic       ps;
  logic       ns;
  logic [1:0] req;
  logic       hlda;
  logic       cpu_hold;
  logic [1:0] grant;
  logic       HLDA;
  logic       busy;
  logic       perr;

  int checks;
  int errors;
  int phase;
  int ack_cnt;
  logic auto_hlda;
  logic last_ps;

  typedef struct packed {
    logic [1:0] req;
    logic       ps;
    logic       hlda;
    logic       hold;
    logic [1:0] grant;
    logic       hl;
    logic       busy;
    logic       perr;
  } vec_t;

  vec_t tbl [15];

  bus_hold_controller #(
    .NUM_REQ       (2),
    .MAX_HOLD_CLKS (4)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .cpu_clock_posedge (ps),
    .cpu_clock_negedge (ns),
    .req               (req),
    .cpu_hlda          (hlda),
    .cpu_hold          (cpu_hold),
    .grant             (grant),
    .HLDA              (HLDA),
    .busy              (busy),
    .protocol_error    (perr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock with the given CPU-edge strobe; checks per-cycle invariants and
  // advances the 8088 HLDA model on CPU edges.
  task automatic step(input logic ps_in);
    logic hold_before;
    logic ok;
    hold_before = cpu_hold;
    ps = ps_in;
    @(posedge clock);
    #1;
    ps = 1'b0;
    ok = $onehot0(grant) && (HLDA == (|grant)) && (ps_in || (cpu_hold == hold_before));
    chk("invariant", 8'(ok), 8'd1);
    if (auto_hlda && ps_in) begin
      if (!cpu_hold) begin
        hlda    = 1'b0;
        ack_cnt = 0;
      end else if (!hlda) begin
        ack_cnt++;
        if (ack_cnt >= ACK_DLY) hlda = 1'b1;
      end
    end
  endtask

  // CPU clock is four system clocks; the strobe lands on the first.
  task automatic tick();
    last_ps = (phase == 0);
    phase   = (phase + 1) % 4;
    step(last_ps);
  endtask

  task automatic wait_grant(input string name, output logic [1:0] g);
    int n;
    n = 0;
    while (grant == 2'b00 && n < 400) begin
      tick();
      n++;
    end
    if (grant == 2'b00) chk({name, "_timeout"}, 8'd0, 8'd1);
    g = grant;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || cpu_hold) && n < 400) begin
      tick();
      n++;
    end
    chk({name, "_idle"}, 8'({busy, cpu_hold}), 8'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    hlda    = 1'b0;
    ack_cnt = 0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    phase   = 0;
  endtask

  logic [1:0] g;
  int cnt;
  int seen_hold;

  initial begin
    checks = 0; errors = 0; phase = 0; ack_cnt = 0;
    auto_hlda = 1'b0; last_ps = 1'b0;
    reset_n = 1'b0; ps = 1'b0; ns = 1'b0; req = 2'b00; hlda = 1'b0;

    // Cycle table: inputs, then outputs seen after that clock.
    //            req    ps    hlda  hold  grant  HLDA  busy  perr
    tbl[0]  = '{2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{2'b01, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{2'b01, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{2'b01, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{2'b01, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1};

    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs", 8'({cpu_hold, grant, HLDA, busy, perr}), 8'd0);
    reset_n = 1'b1;

    // Single tenure, voluntary release, then a protocol error.
    for (int i = 0; i < 15; i++) begin
      req  = tbl[i].req;
      hlda = tbl[i].hlda;
      step(tbl[i].ps);
      chk($sformatf("vec%0d", i), 8'({cpu_hold, grant, HLDA, busy, perr}),
          8'({tbl[i].hold, tbl[i].grant, tbl[i].hl, tbl[i].busy, tbl[i].perr}));
    end

    // Reset mid-tenure clears outputs asynchronously (pointer is 1 beforehand).
    auto_hlda = 1'b1;
    hlda = 1'b0;
    req  = 2'b01;
    wait_grant("midrst", g);
    chk("midrst_grant", 8'(g), 8'h01);
    chk("midrst_perr_before", 8'(perr), 8'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_outputs", 8'({cpu_hold, grant, HLDA, busy, perr}), 8'd0);
    req = 2'b00;
    do_reset();

    // Contention: grants alternate, HOLD low between tenures.
    req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      wait_grant($sformatf("cont%0d", t), g);
      chk($sformatf("cont%0d_grant", t), 8'(g), (t % 2 == 0) ? 8'h01 : 8'h02);
      repeat (6) tick();
      chk($sformatf("cont%0d_held", t), 8'(grant), 8'(g));
      req = 2'b11 & ~g;
      tick();
      chk($sformatf("cont%0d_drop", t), 8'({grant, HLDA}), 8'd0);
      cnt = 0;
      while (cpu_hold && cnt < 40) begin
        tick();
        cnt++;
      end
      chk($sformatf("cont%0d_holdlow", t), 8'(cpu_hold), 8'd0);
      req = 2'b11;
    end
    req = 2'b00;
    wait_idle("cont");

    // Timeout: requester 0 held past its tenure.
    do_reset();
    req = 2'b01;
    wait_grant("to", g);
    chk("to_grant", 8'(g), 8'h01);
    cnt = 0;
    for (int n = 0; n < 200 && grant != 2'b00; n++) begin
      logic pre;
      pre = |grant;
      tick();
      if (pre && last_ps) cnt++;
    end
    chk("to_posedges", 8'(cnt), 8'd4);
    wait_idle("to_rel");
    seen_hold = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (cpu_hold || grant != 2'b00) seen_hold++;
    end
    chk("to_inelig", 8'(seen_hold), 8'd0);
    req = 2'b11;
    wait_grant("to_other", g);
    chk("to_other_grant", 8'(g), 8'h02);
    req = 2'b01;
    wait_idle("to_other");
    seen_hold = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (cpu_hold || grant != 2'b00) seen_hold++;
    end
    chk("to_still_inelig", 8'(seen_hold), 8'd0);
    req = 2'b00;
    tick();
    req = 2'b01;
    wait_grant("to_rearm", g);
    chk("to_rearm_grant", 8'(g), 8'h01);
    req = 2'b00;
    wait_idle("to_end");

    // Early drop while waiting for the ack: one-clock grant, then release.
    do_reset();
    req = 2'b01;
    cnt = 0;
    while (!cpu_hold && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("early_hold", 8'(cpu_hold), 8'd1);
    req = 2'b00;
    cnt = 0;
    g   = 2'b00;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (grant != 2'b00) begin
        cnt++;
        g = grant;
      end
      if (cnt > 0 && !busy && !cpu_hold) break;
    end
    chk("early_grant_clks", 8'(cnt), 8'd1);
    chk("early_grant_val", 8'(g), 8'h01);
    chk("early_idle", 8'({busy, cpu_hold, perr}), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_hold_controller.md
# bus_hold_controller

Sequences ownership of the PCjr system bus between the 8088 and up to `NUM_REQ` secondary bus masters (video refresh fetch, expansion DMA). Drives the CPU HOLD pin, qualifies the CPU's HLDA into a single bus-grant acknowledge for the command-strobe decoder, and grants the bus round-robin with a bounded tenure. Sits beside the command-strobe decoder, clocked by the system `clock`, using the same CPU-clock edge strobes.

## Interface
- `NUM_REQ`, 2: number of secondary requesters (2..4).
- `MAX_HOLD_CLKS`, 64: maximum tenure in CPU clocks before forced release (1..255).
- `clock` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cpu_clock_posedge` in 1: one-`clock` strobe at the CPU clock rising edge.
- `cpu_clock_negedge` in 1: one-`clock` strobe at the CPU clock falling edge (unused for state; passed for symmetry, tied off internally).
- `req` in NUM_REQ: level bus requests, one per secondary master.
- `cpu_hlda` in 1: HLDA from the 8088.
- `cpu_hold` out 1: HOLD to the 8088.
- `grant` out NUM_REQ: one-hot bus grant; at most one bit set.
- `HLDA` out 1: qualified acknowledge to the strobe decoder; high exactly while `grant` is non-zero.
- `busy` out 1: state is not IDLE.
- `protocol_error` out 1: sticky; set on unexpected `cpu_hlda` drop.

## Operation
- States: IDLE, WAIT_ACK, GRANT, RELEASE.
- IDLE: on `cpu_clock_posedge` with any eligible `req` bit, latch winner (round-robin from pointer `rr_ptr`), set `cpu_hold`=1, go WAIT_ACK.
- WAIT_ACK: `cpu_hlda`=1 sampled on `clock` -> GRANT; `grant[winner]`=1 and `HLDA`=1 from the next `clock`; tenure counter cleared. If `req[winner]` drops before ack: stay, complete ack, then release with zero tenure.
- GRANT: counter increments on each `cpu_clock_posedge`, saturating at `MAX_HOLD_CLKS`. Exit when `req[winner]`=0 or counter == `MAX_HOLD_CLKS` -> RELEASE; `grant`/`HLDA` cleared on that same transition.
- RELEASE: `cpu_hold` drops on the next `cpu_clock_posedge`; wait `cpu_hlda`=0 -> IDLE; `rr_ptr` = winner+1 mod NUM_REQ.
- Forced release (timeout): winner marked ineligible until its `req` goes low for at least one `clock`; other requesters unaffected.
- `cpu_hlda` falls while in GRANT: `grant`/`HLDA` cleared next `clock`, `cpu_hold` cleared, `protocol_error` set, -> IDLE, `rr_ptr` advances.
- Counter width `$clog2(MAX_HOLD_CLKS+1)`, unsigned, saturating; never wraps.
- Round-robin: search starts at `rr_ptr`, wraps past NUM_REQ-1 to 0.

## Timing
- Reset values: `cpu_hold`=0, `grant`=0, `HLDA`=0, `busy`=0, `protocol_error`=0, `rr_ptr`=0, counter=0, eligibility all 1, state IDLE.
- `cpu_hold` changes only on `cpu_clock_posedge` cycles (the 8088 samples HOLD on the CPU rising edge).
- Request-to-HOLD latency: up to one CPU clock plus one `clock`.
- HLDA-to-grant latency: exactly one `clock`.
- Release-to-HOLD-low: `grant` drops in the exit `clock`; `cpu_hold` drops at the next `cpu_clock_posedge`.
- `req` asserted in RELEASE is serviced only after IDLE is re-entered; no back-to-back tenures without HOLD low.
- Simultaneous `req` drop and timeout in the same cycle: treated as voluntary release (no ineligibility).
- Asserting `reset_n` low mid-tenure clears every output in the same `clock` (asynchronous).

## Structure
- Package `bus_hold_pkg`: state enum `bus_hold_state_t`, `MAX_NUM_REQ`=4.
- Sub-module `rr_pick`: combinational round-robin one-hot selector (`req`, eligibility, `rr_ptr` -> one-hot winner, index, valid).

## Test plan
- Single request: `req`=01, `cpu_hlda` rises 3 CPU clocks after HOLD -> `grant`=01 one `clock` later, `HLDA`=1; `req` drops -> `grant`=00 same cycle, HOLD low at next posedge.
- Contention: `req`=11 continuously, each tenure released voluntarily -> grants alternate 01, 10, 01; HOLD low between each.
- Timeout: `MAX_HOLD_CLKS`=4, `req[0]` held -> grant removed after 4 CPU posedges; `req[0]` not regranted until it drops one `clock`; `req[1]` served meanwhile.
- Protocol error: drop `cpu_hlda` during GRANT -> `grant`=0 next `clock`, `protocol_error`=1 stays set, returns to IDLE.
- Reset mid-tenure: `reset_n` low in GRANT -> `cpu_hold`, `grant`, `HLDA`, `busy`, `protocol_error` all 0 immediately; `rr_ptr`=0.
- Early drop: `req[0]` drops in WAIT_ACK -> after `cpu_hlda` rises, one-`clock` `grant`=01 then release; no hang.
